// File: rtl/data_mem_if.sv
// Load/store data memory bus between the pipeline's load/store stage (master)
// and a memory responder (slave).
`timescale 1ns/1ps
interface data_mem_if;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_be_i;
  logic        mem_ack_o;
  logic        mem_stall_o;
  logic [31:0] mem_rdata_o;
  logic        mem_err_o;

  modport master (
    output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_be_i,
    input  mem_ack_o, mem_stall_o, mem_rdata_o, mem_err_o
  );

  modport slave (
    input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_be_i,
    output mem_ack_o, mem_stall_o, mem_rdata_o, mem_err_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-beat data memory responder: byte-enabled word array, fixed wait
// states between acceptance and a one-cycle ack, stall while in flight.
`timescale 1ns/1ps
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  data_mem_if.slave  bus
);

  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  logic [31:0] mem_array [DEPTH];

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  inr_q, inr_d;
  logic                  ack_q, ack_d;
  logic                  stall_q, stall_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [31:0]           off;
  logic                  req_inr;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic                  accept;

  logic                  commit;
  logic                  c_we;
  logic [ADDR_WIDTH-1:0] c_idx;
  logic [31:0]           c_wdata;
  logic [3:0]            c_be;
  logic                  c_inr;

  // Range is checked on the full 32-bit offset so high addresses never alias.
  always_comb begin
    off     = bus.mem_addr_i - BASE_ADDR;
    req_inr = (bus.mem_addr_i >= BASE_ADDR) && ((off >> (ADDR_WIDTH + 2)) == 32'd0);
    req_idx = off[ADDR_WIDTH+1:2];
    accept  = bus.mem_req_i && !stall_q && (state_q != ST_WAIT);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    inr_d   = inr_q;
    commit  = 1'b0;
    c_we    = we_q;
    c_idx   = idx_q;
    c_wdata = wdata_q;
    c_be    = be_q;
    c_inr   = inr_q;

    case (state_q)
      ST_IDLE, ST_ACK: begin
        if (accept) begin
          we_d    = bus.mem_we_i;
          idx_d   = req_idx;
          wdata_d = bus.mem_wdata_i;
          be_d    = bus.mem_be_i;
          inr_d   = req_inr;
          if (WAIT_CYCLES == 0) begin
            // Zero wait states: the accepting edge is also the commit edge.
            state_d = ST_ACK;
            commit  = 1'b1;
            c_we    = bus.mem_we_i;
            c_idx   = req_idx;
            c_wdata = bus.mem_wdata_i;
            c_be    = bus.mem_be_i;
            c_inr   = req_inr;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    stall_d = (state_d == ST_WAIT);
    ack_d   = (state_d == ST_ACK);
    rdata_d = (commit && !c_we && c_inr) ? mem_array[c_idx] : 32'd0;
    err_d   = commit && !c_inr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      inr_q   <= 1'b0;
      ack_q   <= 1'b0;
      stall_q <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      inr_q   <= inr_d;
      ack_q   <= ack_d;
      stall_q <= stall_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array contents survive reset; only the write strobe is gated by it.
  always_ff @(posedge clk) begin
    if (!rst && commit && c_we && c_inr) begin
      for (int i = 0; i < 4; i++) begin
        if (c_be[i]) mem_array[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

  assign bus.mem_ack_o   = ack_q;
  assign bus.mem_stall_o = stall_q;
  assign bus.mem_rdata_o = rdata_q;
  assign bus.mem_err_o   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at WAIT_CYCLES = 1, 0 and 3.
`timescale 1ns/1ps
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_if ia();
  data_mem_if ib();
  data_mem_if ic();

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) u_dut_w1 (
    .clk(clk), .rst(rst), .bus(ia));
  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut_w0 (
    .clk(clk), .rst(rst), .bus(ib));
  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) u_dut_w3 (
    .clk(clk), .rst(rst), .bus(ic));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on the WAIT_CYCLES=1 instance; starts and ends #1 after an edge.
  task automatic a_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rdata, output logic err,
                       output int lat, output int stalls);
    ia.mem_req_i   = 1'b1;
    ia.mem_we_i    = we;
    ia.mem_addr_i  = addr;
    ia.mem_wdata_i = wdata;
    ia.mem_be_i    = be;
    @(posedge clk); #1;
    ia.mem_req_i = 1'b0;
    lat    = 1;
    stalls = 0;
    while (ia.mem_ack_o !== 1'b1 && lat < 20) begin
      if (ia.mem_stall_o === 1'b1) stalls++;
      @(posedge clk); #1;
      lat++;
    end
    rdata = ia.mem_rdata_o;
    err   = ia.mem_err_o;
    @(posedge clk); #1;
    check("a_ack_fall", {31'd0, ia.mem_ack_o}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, stl, acks;

  initial begin
    ia.mem_req_i = 0; ia.mem_we_i = 0; ia.mem_addr_i = 0; ia.mem_wdata_i = 0; ia.mem_be_i = 0;
    ib.mem_req_i = 0; ib.mem_we_i = 0; ib.mem_addr_i = 0; ib.mem_wdata_i = 0; ib.mem_be_i = 0;
    ic.mem_req_i = 0; ic.mem_we_i = 0; ic.mem_addr_i = 0; ic.mem_wdata_i = 0; ic.mem_be_i = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack",   {31'd0, ia.mem_ack_o},   32'd0);
    check("rst_stall", {31'd0, ia.mem_stall_o}, 32'd0);
    check("rst_rdata", ia.mem_rdata_o,          32'd0);
    check("rst_err",   {31'd0, ia.mem_err_o},   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // WAIT_CYCLES=1: full-word store then load
    a_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat, stl);
    check("st_lat",   lat, 2);
    check("st_stall", stl, 1);
    check("st_rdata", rd, 32'd0);
    check("st_err",   {31'd0, er}, 32'd0);
    a_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, stl);
    check("ld_lat",   lat, 2);
    check("ld_rdata", rd, 32'hDEAD_BEEF);
    check("ld_err",   {31'd0, er}, 32'd0);

    // byte lane 1 store
    a_txn(1'b1, 32'h10, 32'h0000_AA00, 4'b0010, rd, er, lat, stl);
    a_txn(1'b0, 32'h11, 32'h0, 4'h0, rd, er, lat, stl);
    check("byte_rdata", rd, 32'hDEAD_AAEF);

    // be=0 store changes nothing
    a_txn(1'b1, 32'h10, 32'h0, 4'h0, rd, er, lat, stl);
    a_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, stl);
    check("be0_rdata", rd, 32'hDEAD_AAEF);

    // idle with garbage inputs
    ia.mem_we_i = 1'b1; ia.mem_addr_i = 32'h10; ia.mem_wdata_i = 32'h0; ia.mem_be_i = 4'hF;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      acks += int'(ia.mem_ack_o) + int'(ia.mem_stall_o);
    end
    check("idle_garbage", acks, 0);

    // out of range: first word past the array, and one that would alias 0x10
    a_txn(1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat, stl);
    check("oor_ld_lat",   lat, 2);
    check("oor_ld_err",   {31'd0, er}, 32'd1);
    check("oor_ld_rdata", rd, 32'd0);
    a_txn(1'b1, 32'h1010, 32'hFFFF_FFFF, 4'hF, rd, er, lat, stl);
    check("oor_st_err", {31'd0, er}, 32'd1);
    a_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, stl);
    check("oor_st_noalias", rd, 32'hDEAD_AAEF);
    check("oor_clr_err",    {31'd0, er}, 32'd0);

    // reset during WAIT of a store to 0x20
    a_txn(1'b1, 32'h20, 32'h1234_5678, 4'hF, rd, er, lat, stl);
    ia.mem_req_i = 1'b1; ia.mem_we_i = 1'b1; ia.mem_addr_i = 32'h20;
    ia.mem_wdata_i = 32'hCAFE_F00D; ia.mem_be_i = 4'hF;
    @(posedge clk); #1;
    check("rw_stall_pre", {31'd0, ia.mem_stall_o}, 32'd1);
    rst = 1'b1;
    #1;
    check("rw_ack",   {31'd0, ia.mem_ack_o},   32'd0);
    check("rw_stall", {31'd0, ia.mem_stall_o}, 32'd0);
    check("rw_rdata", ia.mem_rdata_o,          32'd0);
    check("rw_err",   {31'd0, ia.mem_err_o},   32'd0);
    ia.mem_req_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      acks += int'(ia.mem_ack_o);
    end
    check("rw_no_ack", acks, 0);
    a_txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, stl);
    check("rw_keep", rd, 32'h1234_5678);

    // WAIT_CYCLES=0: four back-to-back stores then four back-to-back loads
    ib.mem_req_i = 1'b1; ib.mem_we_i = 1'b1; ib.mem_be_i = 4'hF;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      ib.mem_addr_i  = 32'(4 * i);
      ib.mem_wdata_i = 32'hA000_0000 | 32'(i);
      @(posedge clk); #1;
      acks += int'(ib.mem_ack_o);
      check("b2b_st_stall", {31'd0, ib.mem_stall_o}, 32'd0);
    end
    check("b2b_st_acks", acks, 4);
    ib.mem_we_i = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      ib.mem_addr_i = 32'(4 * i);
      @(posedge clk); #1;
      acks += int'(ib.mem_ack_o);
      check("b2b_ld_stall", {31'd0, ib.mem_stall_o}, 32'd0);
      check("b2b_ld_rdata", ib.mem_rdata_o, 32'hA000_0000 | 32'(i));
    end
    check("b2b_ld_acks", acks, 4);
    ib.mem_req_i = 1'b0;
    @(posedge clk); #1;
    check("b2b_idle_ack", {31'd0, ib.mem_ack_o}, 32'd0);

    // WAIT_CYCLES=3: store, load asserted during WAIT and held until stalled again
    ic.mem_req_i = 1'b1; ic.mem_we_i = 1'b1; ic.mem_addr_i = 32'h40;
    ic.mem_wdata_i = 32'h5A5A_0F0F; ic.mem_be_i = 4'hF;
    @(posedge clk); #1;
    ic.mem_we_i = 1'b0; ic.mem_wdata_i = 32'h0;
    stl = 0;
    while (ic.mem_ack_o !== 1'b1 && stl < 20) begin
      stl += int'(ic.mem_stall_o);
      @(posedge clk); #1;
    end
    check("w3_stall_cycles", stl, 3);
    check("w3_st_rdata", ic.mem_rdata_o, 32'd0);
    check("w3_st_stall", {31'd0, ic.mem_stall_o}, 32'd0);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (ic.mem_stall_o === 1'b1) ic.mem_req_i = 1'b0;
    end while (ic.mem_ack_o !== 1'b1 && lat < 20);
    check("w3_second_lat", lat, 4);
    check("w3_raw_rdata", ic.mem_rdata_o, 32'h5A5A_0F0F);
    check("w3_raw_err", {31'd0, ic.mem_err_o}, 32'd0);
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      acks += int'(ic.mem_ack_o);
    end
    check("w3_no_dup", acks, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
